// File: rtl/uart2wb.sv
// uart2wb: UART-to-Wishbone debug bridge (Wishbone classic master driven by host byte commands).
// Commands: 'W' + addr + data -> ACK (0x06); 'R' + addr -> data bytes; anything else -> NAK (0x15).
// UART 8N1, LSB first, idle high. Multi-byte fields travel MSB first.
// Optional feature macro: UART2WB_TIMEOUT_EN (bus-cycle timeout, replies NAK on expiry).
module uart2wb #(
   parameter int unsigned addr_width     = 32,
   parameter int unsigned data_width     = 32,
   parameter int unsigned clk_per_bit    = 217,
   parameter int unsigned timeout_cycles = 1024
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    uart_rx,
   output logic                    uart_tx,
   output logic                    wb_cyc,
   output logic                    wb_stb,
   output logic                    wb_we,
   output logic [addr_width-1:0]   wb_adr,
   output logic [data_width-1:0]   wb_dat_o,
   output logic [data_width/8-1:0] wb_sel,
   input  logic                    wb_ack,
   input  logic [data_width-1:0]   wb_dat_i
);

   localparam int unsigned ABYTES = addr_width / 8;
   localparam int unsigned DBYTES = data_width / 8;
   localparam int unsigned SEL_W  = data_width / 8;
   localparam int unsigned MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
   localparam int unsigned BCNT_W = $clog2(MAXB + 1);
   localparam int unsigned CNT_W  = $clog2(clk_per_bit);

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(clk_per_bit - 1);
   localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(clk_per_bit / 2);

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

   // Single-byte reply placed in the top byte of the response shifter
   function automatic logic [data_width-1:0] resp_byte(input logic [7:0] b);
      logic [data_width-1:0] r;
      r = '0;
      r[data_width-1 -: 8] = b;
      return r;
   endfunction

   // ---------------- RX engine ----------------
   logic             rx_meta_q, rx_sync_q, rx_last_q;
   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_valid_c, rx_err_c;

   // Two-flop synchroniser plus previous-value flop for falling-edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_last_q <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_last_q <= rx_sync_q;
      end
   end

   // RX frame tracker: runs in every bridge state so framing never slips
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_c = 1'b0;
      rx_err_c   = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (rx_last_q && !rx_sync_q) begin
               rx_state_d = R_START;
               rx_cnt_d   = '0;
            end
         end
         R_START: begin
            if (rx_cnt_q == BIT_HALF) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               // A start bit that is high again at mid-bit was only a glitch
               rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         R_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         R_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = R_IDLE;
               rx_valid_c = rx_sync_q;
               rx_err_c   = !rx_sync_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // RX engine state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_state_q <= R_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // ---------------- Command / bus / reply FSM ----------------
   state_e                state_q, state_d;
   logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
   logic                  we_q, we_d;
   logic [addr_width-1:0] adr_q, adr_d;
   logic [data_width-1:0] dat_q, dat_d;
   logic                  cyc_q, cyc_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [data_width-1:0] resp_q, resp_d;
   logic [BCNT_W-1:0]     tx_left_q, tx_left_d;
   logic                  tx_active_q, tx_active_d;
   logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
   logic [3:0]            tx_bit_q, tx_bit_d;
   logic                  uart_tx_q, uart_tx_d;
   logic [7:0]            tx_byte_c;

`ifdef UART2WB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(timeout_cycles + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
   logic unused_timeout_c;
   assign unused_timeout_c = (timeout_cycles == 32'd0);
`endif

   // Next-state: command decode, field shifting, bus handshake, reply serialiser
   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      cyc_d       = cyc_q;
      sel_d       = sel_q;
      resp_d      = resp_q;
      tx_left_d   = tx_left_q;
      tx_active_d = tx_active_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      uart_tx_d   = uart_tx_q;
`ifdef UART2WB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      tx_byte_c   = resp_q[data_width-1 -: 8];

      case (state_q)
         S_IDLE, S_CMD: begin
            if (rx_valid_c) begin
               if (rx_shift_q == CMD_WR || rx_shift_q == CMD_RD) begin
                  we_d    = (rx_shift_q == CMD_WR);
                  bcnt_d  = BCNT_W'(ABYTES - 1);
                  state_d = S_ADDR;
               end else begin
                  resp_d    = resp_byte(RSP_NAK);
                  tx_left_d = '0;
                  state_d   = S_RESP;
               end
            end else if (state_q == S_IDLE) begin
               if (rx_state_q != R_IDLE) state_d = S_CMD;
            end else if (rx_err_c || rx_state_q == R_IDLE) begin
               // Framing error or glitch on a command byte is dropped silently
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            if (rx_err_c) begin
               resp_d    = resp_byte(RSP_NAK);
               tx_left_d = '0;
               state_d   = S_RESP;
            end else if (rx_valid_c) begin
               adr_d = (adr_q << 8) | addr_width'(rx_shift_q);
               if (bcnt_q == '0) begin
                  if (we_q) begin
                     bcnt_d  = BCNT_W'(DBYTES - 1);
                     state_d = S_DATA;
                  end else begin
                     cyc_d   = 1'b1;
                     sel_d   = '1;
                     state_d = S_BUS;
                  end
               end else begin
                  bcnt_d = bcnt_q - BCNT_W'(1);
               end
            end
         end
         S_DATA: begin
            if (rx_err_c) begin
               resp_d    = resp_byte(RSP_NAK);
               tx_left_d = '0;
               state_d   = S_RESP;
            end else if (rx_valid_c) begin
               dat_d = (dat_q << 8) | data_width'(rx_shift_q);
               if (bcnt_q == '0) begin
                  cyc_d   = 1'b1;
                  sel_d   = '1;
                  state_d = S_BUS;
               end else begin
                  bcnt_d = bcnt_q - BCNT_W'(1);
               end
            end
         end
         S_BUS: begin
            if (wb_ack) begin
               cyc_d   = 1'b0;
               sel_d   = '0;
               state_d = S_RESP;
               if (we_q) begin
                  resp_d    = resp_byte(RSP_ACK);
                  tx_left_d = '0;
               end else begin
                  resp_d    = wb_dat_i;
                  tx_left_d = BCNT_W'(DBYTES - 1);
               end
`ifdef UART2WB_TIMEOUT_EN
               to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(timeout_cycles - 1)) begin
               // Limit reached with no ack: abandon the cycle and NAK the host
               cyc_d     = 1'b0;
               sel_d     = '0;
               resp_d    = resp_byte(RSP_NAK);
               tx_left_d = '0;
               to_cnt_d  = '0;
               state_d   = S_RESP;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
`endif
            end
         end
         S_RESP: begin
            if (!tx_active_q) begin
               tx_active_d = 1'b1;
               uart_tx_d   = 1'b0;
               tx_cnt_d    = '0;
               tx_bit_d    = '0;
            end else if (tx_cnt_q != BIT_LAST) begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end else begin
               tx_cnt_d = '0;
               if (tx_bit_q == 4'd9) begin
                  // Stop bit has been held a full bit time
                  if (tx_left_q == '0) begin
                     tx_active_d = 1'b0;
                     state_d     = S_IDLE;
                  end else begin
                     tx_left_d = tx_left_q - BCNT_W'(1);
                     resp_d    = resp_q << 8;
                     uart_tx_d = 1'b0;
                     tx_bit_d  = '0;
                  end
               end else begin
                  tx_bit_d  = tx_bit_q + 4'd1;
                  uart_tx_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_c[tx_bit_q[2:0]];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bridge state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         bcnt_q      <= '0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         cyc_q       <= 1'b0;
         sel_q       <= '0;
         resp_q      <= '0;
         tx_left_q   <= '0;
         tx_active_q <= 1'b0;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         uart_tx_q   <= 1'b1;
`ifdef UART2WB_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         cyc_q       <= cyc_d;
         sel_q       <= sel_d;
         resp_q      <= resp_d;
         tx_left_q   <= tx_left_d;
         tx_active_q <= tx_active_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         uart_tx_q   <= uart_tx_d;
`ifdef UART2WB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign uart_tx  = uart_tx_q;
   assign wb_cyc   = cyc_q;
   assign wb_stb   = cyc_q;
   assign wb_we    = we_q;
   assign wb_adr   = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel   = sel_q;

endmodule

// File: tb/tb_uart2wb.sv
// Bench for uart2wb: host UART driver, reply decoder, Wishbone slave model and a command-level reference model.
module tb_uart2wb;

   localparam int unsigned CPB = 8;
   localparam int unsigned TO  = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        uart_rx;
   logic        uart_tx;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel;

   always #5 clock = ~clock;

   uart2wb #(.addr_width(32), .data_width(32), .clk_per_bit(CPB), .timeout_cycles(TO)) dut (
      .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_dat_i(wb_dat_i)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } txn_t;

   int          n_cmp = 0;
   int          n_err = 0;

   // Slave model
   int          wait_states = 0;
   int          wait_cnt = 0;
   logic        ack_en = 1'b1;
   logic [31:0] slave_rdata = '0;
   assign wb_ack   = wb_cyc && wb_stb && ack_en && (wait_cnt == wait_states);
   assign wb_dat_i = slave_rdata;

   always @(posedge clock) begin
      if (!wb_cyc)      wait_cnt <= 0;
      else if (!wb_ack) wait_cnt <= wait_cnt + 1;
   end

   // Bus observer: transfers, cycle lengths, stability of request fields
   txn_t txn_q[$];
   int   len_q[$];
   int   cyc_len = 0;
   int   unstable = 0;
   txn_t first;
   always @(negedge clock) begin
      if (wb_cyc === 1'b1) begin
         if (cyc_len == 0) first = {wb_we, wb_adr, wb_dat_o, wb_sel};
         else if ({wb_we, wb_adr, wb_dat_o, wb_sel} !== first) unstable++;
         if (wb_stb !== 1'b1) unstable++;
         cyc_len++;
         if (wb_ack) txn_q.push_back({wb_we, wb_adr, wb_dat_o, wb_sel});
      end else begin
         if (cyc_len != 0) len_q.push_back(cyc_len);
         cyc_len = 0;
      end
   end

   // Reply decoder
   logic [7:0] tx_q[$];
   int         tx_ferr = 0;
   always begin
      logic [7:0] b;
      @(negedge uart_tx);
      repeat (CPB / 2) @(posedge clock);
      #1;
      if (uart_tx !== 1'b0) tx_ferr++;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clock);
         #1;
         b[i] = uart_tx;
      end
      repeat (CPB) @(posedge clock);
      #1;
      if (uart_tx !== 1'b1) tx_ferr++;
      tx_q.push_back(b);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(posedge clock);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(posedge clock);
      uart_rx = 1'b1;
      if (!stop_bit) repeat (CPB) @(posedge clock);
   endtask

   logic [7:0] cmd_q[$];
   logic [7:0] exp_q[$];

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) cmd_q.push_back(w[8*i +: 8]);
   endtask

   // Sends cmd_q (frame bad_idx gets a low stop bit, -1 = none) and checks against the command model
   task automatic run_cmd(input int bad_idx, input int waits, input logic [31:0] rdata,
                          input logic no_ack, input string tag);
      logic       exp_txn;
      txn_t       exp_t;
      int         exp_len;
      logic [7:0] got;
      exp_q.delete();
      exp_txn = 1'b0;
      exp_t   = '0;
      exp_len = 0;
      if (bad_idx >= 0) begin
         exp_q.push_back(8'h15);
      end else if (cmd_q[0] == 8'h57 || cmd_q[0] == 8'h52) begin
         exp_t.we  = (cmd_q[0] == 8'h57);
         exp_t.adr = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
         exp_t.sel = 4'hF;
         if (no_ack) begin
            exp_q.push_back(8'h15);
            exp_len = TO;
         end else begin
            exp_txn = 1'b1;
            exp_len = waits + 1;
            if (exp_t.we) begin
               exp_t.dat = {cmd_q[5], cmd_q[6], cmd_q[7], cmd_q[8]};
               exp_q.push_back(8'h06);
            end else begin
               for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);
            end
         end
      end else begin
         exp_q.push_back(8'h15);
      end

      wait_states = waits;
      slave_rdata = rdata;
      ack_en      = !no_ack;
      tx_q.delete();
      txn_q.delete();
      len_q.delete();
      for (int i = 0; i < cmd_q.size(); i++) begin
         send_byte(cmd_q[i], (i == bad_idx) ? 1'b0 : 1'b1);
         if (i == bad_idx) break;
      end
      for (int c = 0; c < 4000 && tx_q.size() < exp_q.size(); c++) @(posedge clock);
      repeat (3 * CPB) @(posedge clock);
      #1;

      check({tag, "_nreply"}, 64'(tx_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         check({tag, "_reply"}, 64'(got), 64'(exp_q[i]));
      end
      check({tag, "_ntxn"}, 64'(txn_q.size()), 64'(exp_txn));
      if (exp_txn && txn_q.size() > 0) begin
         check({tag, "_we"},  64'(txn_q[0].we),  64'(exp_t.we));
         check({tag, "_adr"}, 64'(txn_q[0].adr), 64'(exp_t.adr));
         check({tag, "_sel"}, 64'(txn_q[0].sel), 64'(exp_t.sel));
         if (exp_t.we) check({tag, "_dat"}, 64'(txn_q[0].dat), 64'(exp_t.dat));
      end
      check({tag, "_ncyc"}, 64'(len_q.size()), 64'(exp_len != 0));
      if (exp_len != 0 && len_q.size() > 0) check({tag, "_cyclen"}, 64'(len_q[0]), 64'(exp_len));
      check({tag, "_cyc_idle"}, 64'(wb_cyc), 64'(0));
   endtask

   initial begin
      int          r;
      logic [7:0]  b;
      logic [31:0] a, d;

      // Reset values
      reset   = 1'b1;
      uart_rx = 1'b1;
      #3 reset = 1'b0;
      #1;
      check("rst_uart_tx", 64'(uart_tx), 64'(1));
      check("rst_cyc", 64'(wb_cyc), 64'(0));
      check("rst_stb", 64'(wb_stb), 64'(0));
      check("rst_we", 64'(wb_we), 64'(0));
      check("rst_adr", 64'(wb_adr), 64'(0));
      check("rst_dat", 64'(wb_dat_o), 64'(0));
      check("rst_sel", 64'(wb_sel), 64'(0));
      repeat (4) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      repeat (2 * CPB) @(posedge clock);

      // Directed write, zero wait states
      cmd_q = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_cmd(-1, 0, 32'h0, 1'b0, "s1_write");

      // Directed read
      cmd_q = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
      run_cmd(-1, 0, 32'h12345678, 1'b0, "s2_read");

      // Bad command, then a good read
      cmd_q = '{8'h41};
      run_cmd(-1, 0, 32'h0, 1'b0, "s3_badcmd");
      cmd_q = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
      run_cmd(-1, 0, 32'h12345678, 1'b0, "s3_read");

      // Framing error on third address byte, then a good write
      cmd_q = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_cmd(3, 0, 32'h0, 1'b0, "s4_frame");
      cmd_q = '{8'h57, 8'hA5, 8'h5A, 8'h00, 8'h04, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      run_cmd(-1, 1, 32'h0, 1'b0, "s4_write");

      // Read with 5 wait states
      cmd_q = '{8'h52, 8'h80, 8'h00, 8'h00, 8'h20};
      run_cmd(-1, 5, 32'h89ABCDEF, 1'b0, "s5_wait");

      // Randomised commands
      for (int n = 0; n < 10; n++) begin
         r = $urandom_range(0, 9);
         a = $urandom;
         d = $urandom;
         cmd_q.delete();
         if (r < 4) begin
            cmd_q.push_back(8'h57);
            push_word(a);
            push_word(d);
         end else if (r < 8) begin
            cmd_q.push_back(8'h52);
            push_word(a);
         end else begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h57 || b == 8'h52) b = 8'h00;
            cmd_q.push_back(b);
         end
         run_cmd(-1, $urandom_range(0, 3), $urandom, 1'b0, "rnd");
      end

`ifdef UART2WB_TIMEOUT_EN
      // Slave never acks: cycle abandoned after the limit, NAK returned
      cmd_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
      run_cmd(-1, 0, 32'h0, 1'b1, "s6_timeout");
`endif

      // Reset pulse in the middle of a bus cycle
      cmd_q.delete();
      cmd_q.push_back(8'h52);
      push_word($urandom);
      ack_en = 1'b0;
      tx_q.delete();
      txn_q.delete();
      for (int i = 0; i < cmd_q.size(); i++) send_byte(cmd_q[i], 1'b1);
      for (int c = 0; c < 200 && wb_cyc !== 1'b1; c++) @(posedge clock);
      #1;
      check("s6_cyc_seen", 64'(wb_cyc), 64'(1));
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("s6_rst_cyc", 64'(wb_cyc), 64'(0));
      check("s6_rst_stb", 64'(wb_stb), 64'(0));
      check("s6_rst_uart_tx", 64'(uart_tx), 64'(1));
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      ack_en = 1'b1;
      repeat (40 * CPB) @(posedge clock);
      #1;
      check("s6_no_reply", 64'(tx_q.size()), 64'(0));
      check("s6_no_txn", 64'(txn_q.size()), 64'(0));

      // Bridge still usable after the reset
      cmd_q = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00};
      run_cmd(-1, 2, 32'h0BADF00D, 1'b0, "s6_after");

      check("tx_framing", 64'(tx_ferr), 64'(0));
      check("bus_stable", 64'(unstable), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
